// File: rtl/mem_pkg.sv
// Shared data-memory definitions: funct3 encodings, the store-buffer entry
// layout and the legal-store check.
package mem_pkg;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  funct3;
    } sbuf_entry_t;

    function automatic logic sbuf_legal_f3(input logic [2:0] f3);
        return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    endfunction

endpackage

// File: rtl/store_buffer.sv
// Posted-store buffer: in-order queue of sb/sh/sw between execute and the
// data-memory write port, stalling loads that hit a pending store's word.
module store_buffer
    import mem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [2:0]  st_funct3,
    input  logic        ld_valid,
    input  logic [31:0] ld_addr,
    output logic        ld_stall,
    input  logic        mem_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_funct3,
    output logic        fence_busy,
    output logic        err_illegal
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW + 1)'(DEPTH);

    sbuf_entry_t      entry_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             err_q, err_d;

    logic             full, empty;
    logic             accept, push, pop;
    sbuf_entry_t      head;

    assign full   = (count_q == DEPTH_C);
    assign empty  = (count_q == '0);
    assign accept = st_valid && !full;
    assign push   = accept && sbuf_legal_f3(st_funct3);
    assign pop    = !empty && mem_ready;
    assign head   = entry_q[rd_ptr_q];

    assign st_ready    = !full;
    assign mem_we      = !empty;
    assign fence_busy  = !empty;
    assign err_illegal = err_q;
    assign mem_addr    = empty ? 32'h0 : head.addr;
    assign mem_wdata   = empty ? 32'h0 : head.data;
    assign mem_funct3  = empty ? 3'h0  : head.funct3;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) count_d = count_q + 1'b1;
        if (!push && pop) count_d = count_q - 1'b1;
        err_d    = err_q || (accept && !sbuf_legal_f3(st_funct3));
    end

    // An entry is live when its distance from the head is below count; the
    // head stays live in its pop cycle, and this cycle's push is not yet live.
    always_comb begin
        logic [PW-1:0] offset;
        ld_stall = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            offset = PW'(i) - rd_ptr_q;
            if (ld_valid && ({1'b0, offset} < count_q) && (entry_q[i].addr == ld_addr))
                ld_stall = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) entry_q[wr_ptr_q] <= '{addr: st_addr, data: st_data, funct3: st_funct3};
    end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: scenario tasks plus a scoreboard of
// expected port writes, popped whenever the DUT commits a store.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [2:0]  st_funct3;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_stall;
    logic        mem_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_funct3;
    logic        fence_busy;
    logic        err_illegal;

    logic [66:0] exp_q[$];
    int          tests_run = 0;
    int          tests_failed = 0;

    store_buffer #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
        .st_data(st_data), .st_funct3(st_funct3),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_stall(ld_stall),
        .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_funct3(mem_funct3),
        .fence_busy(fence_busy), .err_illegal(err_illegal)
    );

    always #5 clk = ~clk;

    // One clock: scoreboard at the falling edge, then advance to just past
    // the rising edge so the caller can set up the next cycle's inputs.
    task automatic cycle();
        logic [66:0] exp;
        @(negedge clk);
        if (rst) begin
            exp_q.delete();
        end else begin
            if (mem_we && mem_ready) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL commit_unexpected: got addr=%h data=%h f3=%0d, expected no write",
                             mem_addr, mem_wdata, mem_funct3);
                end else begin
                    exp = exp_q.pop_front();
                    if ({mem_addr, mem_wdata, mem_funct3} !== exp) begin
                        tests_failed++;
                        $display("FAIL commit_order: got addr=%h data=%h f3=%0d, expected addr=%h data=%h f3=%0d",
                                 mem_addr, mem_wdata, mem_funct3, exp[66:35], exp[34:3], exp[2:0]);
                    end
                end
            end
            if (st_valid && st_ready && st_funct3 <= 3'd2)
                exp_q.push_back({st_addr, st_data, st_funct3});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    task automatic set_store(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
        st_valid = v; st_addr = a; st_data = d; st_funct3 = f;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle(); cycle();
        rst = 1'b0;
        ld_valid = 1'b1; ld_addr = 32'h0;
        #1;
        check("reset_mem_we", 32'(mem_we), 32'd0);
        check("reset_st_ready", 32'(st_ready), 32'd1);
        check("reset_ld_stall", 32'(ld_stall), 32'd0);
        check("reset_fence_busy", 32'(fence_busy), 32'd0);
        check("reset_err_illegal", 32'(err_illegal), 32'd0);
        check("reset_mem_addr", mem_addr, 32'd0);
        ld_valid = 1'b0;
    endtask

    task automatic test_single();
        mem_ready = 1'b1;
        set_store(1'b1, 32'h10, 32'hDEADBEEF, 3'b010);
        cycle();
        set_store(1'b0, 32'h0, 32'h0, 3'b000);
        check("single_mem_we", 32'(mem_we), 32'd1);
        check("single_addr", mem_addr, 32'h10);
        check("single_data", mem_wdata, 32'hDEADBEEF);
        check("single_f3", 32'(mem_funct3), 32'd2);
        check("single_busy", 32'(fence_busy), 32'd1);
        cycle();
        check("single_empty_we", 32'(mem_we), 32'd0);
        check("single_busy_fall", 32'(fence_busy), 32'd0);
    endtask

    task automatic test_fill();
        mem_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            set_store(1'b1, 32'(i), 32'h100 + 32'(i), 3'b010);
            cycle();
        end
        check("fill_full_ready", 32'(st_ready), 32'd0);
        set_store(1'b1, 32'h5, 32'h105, 3'b010);
        cycle();
        check("fill_hold_addr", mem_addr, 32'h1);
        check("fill_still_full", 32'(st_ready), 32'd0);
        set_store(1'b0, 32'h0, 32'h0, 3'b000);
        mem_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("fill_drain_addr", mem_addr, 32'(i));
            cycle();
        end
        check("fill_drained", 32'(mem_we), 32'd0);
    endtask

    task automatic test_conflict();
        mem_ready = 1'b0;
        set_store(1'b1, 32'h20, 32'hAB, 3'b000);
        cycle();
        set_store(1'b0, 32'h0, 32'h0, 3'b000);
        ld_valid = 1'b1; ld_addr = 32'h20; #1;
        check("conflict_hit", 32'(ld_stall), 32'd1);
        ld_addr = 32'h21; #1;
        check("conflict_neighbour", 32'(ld_stall), 32'd0);
        ld_addr = 32'h20; mem_ready = 1'b1; #1;
        check("conflict_pop_cycle", 32'(ld_stall), 32'd1);
        cycle();
        check("conflict_cleared", 32'(ld_stall), 32'd0);
        mem_ready = 1'b0;
        set_store(1'b1, 32'h30, 32'h33, 3'b001);
        ld_addr = 32'h30; #1;
        check("conflict_same_cycle_push", 32'(ld_stall), 32'd0);
        cycle();
        set_store(1'b0, 32'h0, 32'h0, 3'b000);
        check("conflict_after_push", 32'(ld_stall), 32'd1);
        ld_valid = 1'b0; #1;
        check("conflict_no_load", 32'(ld_stall), 32'd0);
        mem_ready = 1'b1;
        cycle();
        check("conflict_drained", 32'(fence_busy), 32'd0);
    endtask

    task automatic test_back_to_back();
        mem_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            set_store(1'b1, 32'h40 + 32'(i), $urandom, 3'($urandom_range(0, 2)));
            cycle();
            check("b2b_ready", 32'(st_ready), 32'd1);
            check("b2b_addr", mem_addr, 32'h40 + 32'(i));
        end
        set_store(1'b0, 32'h0, 32'h0, 3'b000);
        cycle();
        check("b2b_empty", 32'(fence_busy), 32'd0);
    endtask

    task automatic test_illegal();
        mem_ready = 1'b1;
        set_store(1'b1, 32'h50, 32'h55, 3'b011);
        cycle();
        set_store(1'b0, 32'h0, 32'h0, 3'b000);
        check("illegal_flag", 32'(err_illegal), 32'd1);
        check("illegal_not_queued", 32'(mem_we), 32'd0);
        set_store(1'b1, 32'h54, 32'h66, 3'b010);
        cycle();
        set_store(1'b0, 32'h0, 32'h0, 3'b000);
        cycle(); cycle();
        check("illegal_sticky", 32'(err_illegal), 32'd1);
    endtask

    task automatic test_reset_mid();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_store(1'b1, 32'h60 + 32'(i), 32'h600 + 32'(i), 3'b010);
            cycle();
        end
        set_store(1'b0, 32'h0, 32'h0, 3'b000);
        check("mid_pending", 32'(fence_busy), 32'd1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("mid_mem_we", 32'(mem_we), 32'd0);
        check("mid_st_ready", 32'(st_ready), 32'd1);
        check("mid_err_cleared", 32'(err_illegal), 32'd0);
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
    endtask

    initial begin
        rst = 1'b0; mem_ready = 1'b0; ld_valid = 1'b0; ld_addr = 32'h0;
        set_store(1'b0, 32'h0, 32'h0, 3'b000);
        test_reset();
        test_single();
        test_fill();
        test_conflict();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_leftover: got %0d pending, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-store buffer between the CPU datapath and the data memory. It accepts `sb`, `sh` and `sw` requests from the execute stage in one cycle, queues them in order, and drains them into the data-memory write port one per cycle whenever that port is granted. Loads to a word with a pending store are stalled until the buffer no longer holds a store to that word. The CPU issues at most one memory operation per cycle.

## Interface
- `DEPTH`, 4: number of entries; power of two, ≥2.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `st_valid`  in  1  store request this cycle.
- `st_ready`  out  1  buffer can accept a store (`!full`).
- `st_addr`  in  32  word address, in the same format the data memory takes on `address`.
- `st_data`  in  32  store data, low-aligned.
- `st_funct3`  in  3  000 sb, 001 sh, 010 sw.
- `ld_valid`  in  1  a load is presented to data memory this cycle.
- `ld_addr`  in  32  load word address.
- `ld_stall`  out  1  the load must be held; the CPU repeats it next cycle.
- `mem_ready`  in  1  data-memory write port is granted this cycle.
- `mem_we`  out  1  write strobe, drives data-memory `MemWrite`.
- `mem_addr`  out  32  head entry address.
- `mem_wdata`  out  32  head entry data.
- `mem_funct3`  out  3  head entry funct3.
- `fence_busy`  out  1  buffer not empty; fence/ecall hold while high.
- `err_illegal`  out  1  sticky flag: a store with an illegal funct3 was dropped.

## Operation
- Storage: `DEPTH` entries of {addr[31:0], data[31:0], funct3[2:0]}, plus `wr_ptr`/`rd_ptr` of log2(DEPTH) bits that wrap modulo DEPTH, and `count` of log2(DEPTH)+1 bits.
- `full = (count == DEPTH)`, `empty = (count == 0)`.
- Push when `st_valid && st_ready && st_funct3 ∈ {000,001,010}`: write the entry at `wr_ptr`, then increment `wr_ptr`.
- Illegal funct3 with `st_valid && st_ready`: no enqueue; `err_illegal` is set on the next edge and held until `rst`.
- `st_valid` while full: not accepted. The CPU holds the request; the block does not register it.
- Pop when `mem_we && mem_ready`: increment `rd_ptr`.
- `mem_we = !empty`. `mem_addr`, `mem_wdata` and `mem_funct3` come combinationally from the head entry and are 0 when empty.
- Push and pop in the same cycle: `count` is unchanged and both pointers advance. This is legal when full only if a pop occurs, but `st_ready` is still low when full: there is no same-cycle bypass.
- Conflict: `ld_stall = ld_valid && ∃ valid entry i with addr_i == ld_addr`. Comparison is on the full 32-bit word address. The head entry counts as a conflict even in the cycle it pops. A store being pushed in the same cycle is not compared.
- No forwarding; the buffer never merges entries.
- `fence_busy = !empty`.

## Timing
- Reset values: pointers 0, `count` 0, `err_illegal` 0. With the buffer empty this gives `mem_we` 0, `st_ready` 1, `ld_stall` 0 and `fence_busy` 0.
- Reset mid-operation discards all pending stores.
- Latency: a store accepted at edge N is on the memory port during cycle N+1. With `mem_ready` high, it is committed at the end of N+1.
- Throughput: one push and one pop per cycle.
- The `ld_stall` clear latency after the conflicting store pops is 0 cycles: it deasserts in the cycle following the pop edge.
- Order is strict FIFO. Stores to the same word commit in program order.
- `mem_ready` low holds the head entry and all `mem_*` outputs stable.

## Structure
- Shared package `mem_pkg`:
  - funct3 constants `F3_SB`, `F3_SH`, `F3_SW`, `F3_LB`, `F3_LH`, `F3_LW`, `F3_LBU`, `F3_LHU`.
  - `sbuf_entry_t` struct.
  - `sbuf_legal_f3()` function.
- No sub-module. The associative conflict search needs every entry, so storage stays in-block rather than in a generic FIFO.

## Test plan
- Reset, then `sw` addr 0x10 data 0xDEADBEEF with `mem_ready`=1 -> `mem_we`=1 with those values the next cycle; empty after; `fence_busy` falls.
- `mem_ready`=0, push 4 stores (0x1–0x4) -> `st_ready`=0 after the 4th. A 5th `st_valid` is not accepted. Raise `mem_ready` -> drains 0x1,0x2,0x3,0x4 in order over 4 cycles.
- Pending `sb` to 0x20; load 0x20 -> `ld_stall`=1 until the pop edge. Load 0x21 -> `ld_stall`=0.
- Push every cycle with pops every cycle for 20 cycles -> `count` stays at 1. Pointers wrap past DEPTH-1; data order is preserved.
- Store with funct3=011 -> not enqueued and `err_illegal`=1 the next cycle. The flag stays set until `rst`.
- 3 entries pending, assert `rst` -> next cycle `mem_we`=0 and `st_ready`=1; the discarded stores never appear on the port.
